mbc3_rtc_chip: RTL and testbench

Cartridge memory bank controller, MBC3 class, with a real-time clock. It sits between the CPU cartridge bus decode (ics_rom/ics_ram, iadr) and the external ROM/SRAM. It maps ROM and RAM banks at parametrised widths and hosts an RTC with a prescaler, counters, a latch sequence and a day-carry flag. RTC registers are read and written through the 0xA000-0xBFFF window.

---
 rtl/mbc_pkg.sv | 33 +++
 rtl/mbc_rtc.sv | 130 +++++++++++++
 rtl/mbc3_rtc_chip.sv | 110 +++++++++++
 tb/tb_mbc3_rtc_chip.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbc_pkg.sv
// Shared constants for the MBC3 cartridge controller: register region decode,
// RTC register select codes, RTC field widths/limits and the latch arm states.
package mbc_pkg;

  localparam logic [1:0] RGN_ENA    = 2'b00;
  localparam logic [1:0] RGN_ROMB   = 2'b01;
  localparam logic [1:0] RGN_SEL    = 2'b10;
  localparam logic [1:0] RGN_LATCH  = 2'b11;
  localparam logic [1:0] RGN_RAMWIN = 2'b01;

  localparam logic [3:0] ENA_KEY = 4'hA;

  localparam logic [3:0] RTC_SEC = 4'h8;
  localparam logic [3:0] RTC_MIN = 4'h9;
  localparam logic [3:0] RTC_HR  = 4'hA;
  localparam logic [3:0] RTC_DL  = 4'hB;
  localparam logic [3:0] RTC_DH  = 4'hC;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int DAY_W   = 9;
  localparam int SEC_LIM = 60;
  localparam int MIN_LIM = 60;
  localparam int HR_LIM  = 24;
  localparam int DAY_LIM = 512;

  typedef enum logic {
    LATCH_IDLE  = 1'b0,
    LATCH_ARMED = 1'b1
  } latch_st_e;

endpackage

// File: rtl/mbc_rtc.sv
// MBC3 real-time clock: prescaler, live counters, 00->01 latch sequence and
// register access. Build with MBC_RTC_HALT_EN to make the DH halt bit live.
module mbc_rtc
  import mbc_pkg::*;
#(
  parameter int CLK_HZ = 4194304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_latch_we,
  input  logic       i_reg_we,
  input  logic [3:0] i_sel,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0]    r_presc;
  logic [SEC_W-1:0] r_sec, r_l_sec;
  logic [MIN_W-1:0] r_min, r_l_min;
  logic [HR_W-1:0]  r_hr, r_l_hr;
  logic [DAY_W-1:0] r_day, r_l_day;
  logic             r_carry, r_l_carry;
  logic             r_halt, r_l_halt;
  latch_st_e        r_latch_st, w_latch_nx;
  logic             w_do_latch;

  logic w_tick;
  logic w_sec_wrap, w_min_wrap, w_hr_wrap, w_day_wrap;
  logic w_c_min, w_c_hr, w_c_day;

  assign w_tick     = (r_presc == PW'(CLK_HZ - 1)) && !r_halt;
  assign w_sec_wrap = (r_sec == SEC_W'(SEC_LIM - 1));
  assign w_min_wrap = (r_min == MIN_W'(MIN_LIM - 1));
  assign w_hr_wrap  = (r_hr  == HR_W'(HR_LIM - 1));
  assign w_day_wrap = (r_day == DAY_W'(DAY_LIM - 1));
  // Out-of-range values fall through to a plain modulo increment with no carry.
  assign w_c_min = w_sec_wrap;
  assign w_c_hr  = w_c_min & w_min_wrap;
  assign w_c_day = w_c_hr & w_hr_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch_st <= LATCH_IDLE;
    end else begin
      r_latch_st <= w_latch_nx;
    end
  end

  always_comb begin
    w_latch_nx = r_latch_st;
    w_do_latch = 1'b0;
    if (i_latch_we) begin
      w_latch_nx = (i_wdata == 8'h00) ? LATCH_ARMED : LATCH_IDLE;
      w_do_latch = (r_latch_st == LATCH_ARMED) && (i_wdata == 8'h01);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_sec     <= '0;
      r_min     <= '0;
      r_hr      <= '0;
      r_day     <= '0;
      r_carry   <= 1'b0;
      r_halt    <= 1'b0;
      r_l_sec   <= '0;
      r_l_min   <= '0;
      r_l_hr    <= '0;
      r_l_day   <= '0;
      r_l_carry <= 1'b0;
      r_l_halt  <= 1'b0;
    end else begin
      if (!r_halt) r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_sec <= w_sec_wrap ? '0 : r_sec + SEC_W'(1);
        if (w_c_min) r_min <= w_min_wrap ? '0 : r_min + MIN_W'(1);
        if (w_c_hr)  r_hr  <= w_hr_wrap ? '0 : r_hr + HR_W'(1);
        if (w_c_day) begin
          r_day <= w_day_wrap ? '0 : r_day + DAY_W'(1);
          if (w_day_wrap) r_carry <= 1'b1;
        end
      end
      // Latched copy takes the pre-tick values of this same edge.
      if (w_do_latch) begin
        r_l_sec   <= r_sec;
        r_l_min   <= r_min;
        r_l_hr    <= r_hr;
        r_l_day   <= r_day;
        r_l_carry <= r_carry;
        r_l_halt  <= r_halt;
      end
      // Register writes come last so they override the tick for their field.
      if (i_reg_we) begin
        case (i_sel)
          RTC_SEC: begin
            r_sec   <= i_wdata[SEC_W-1:0];
            r_presc <= '0;
          end
          RTC_MIN: r_min <= i_wdata[MIN_W-1:0];
          RTC_HR:  r_hr  <= i_wdata[HR_W-1:0];
          RTC_DL:  r_day[7:0] <= i_wdata;
          RTC_DH: begin
            r_day[8] <= i_wdata[0];
            if (!i_wdata[7]) r_carry <= 1'b0;
`ifdef MBC_RTC_HALT_EN
            r_halt <= i_wdata[6];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    case (i_sel)
      RTC_SEC: o_rdata = 8'(r_l_sec);
      RTC_MIN: o_rdata = 8'(r_l_min);
      RTC_HR:  o_rdata = 8'(r_l_hr);
      RTC_DL:  o_rdata = r_l_day[7:0];
      RTC_DH:  o_rdata = {r_l_carry, r_l_halt, 5'b0, r_l_day[8]};
      default: o_rdata = 8'h00;
    endcase
  end

endmodule

// File: rtl/mbc3_rtc_chip.sv
// MBC3 cartridge controller top: bank registers, ROM/RAM/RTC address mapping and
// write falling-edge detection. Optional DH halt bit via MBC_RTC_HALT_EN.
module mbc3_rtc_chip
  import mbc_pkg::*;
#(
  parameter int ROM_BANK_W = 7,
  parameter int RAM_BANK_W = 2,
  parameter int CLK_HZ     = 4194304
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ics_rom,
  input  logic                    ics_ram,
  input  logic [14:0]             iadr,
  input  logic [7:0]              data,
  input  logic                    write,
  input  logic [3:0]              rom_size,
  input  logic [1:0]              ram_size,
  output logic [14+ROM_BANK_W-1:0] oadr,
  output logic                    sel_rom,
  output logic                    sel_ram,
  output logic                    sel_rtc,
  output logic [7:0]              rtc_dout
);

  localparam int AW = 14 + ROM_BANK_W;
  localparam int RW = 13 + RAM_BANK_W;

  logic                  r_pwrite;
  logic                  r_ena;
  logic [ROM_BANK_W-1:0] r_rbank;
  logic [3:0]            r_sel;

  logic                  w_commit;
  logic                  w_ram_win;
  logic                  w_sel_is_ram;
  logic                  w_sel_is_rtc;
  logic                  w_latch_we;
  logic                  w_reg_we;
  logic [ROM_BANK_W-1:0] w_bank;
  logic [AW-1:0]         w_rom_mask;
  logic [AW-1:0]         w_rom_adr;
  logic [RW-1:0]         w_ram_mask;
  logic [RW-1:0]         w_ram_adr;
  logic [7:0]            w_rtc_rd;

  // Writes commit on the clock edge that first sees the strobe low again.
  assign w_commit = r_pwrite & ~write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwrite <= 1'b0;
      r_ena    <= 1'b0;
      r_rbank  <= '0;
      r_sel    <= '0;
    end else begin
      r_pwrite <= write;
      if (w_commit && ics_rom) begin
        case (iadr[14:13])
          RGN_ENA:  r_ena   <= (data[3:0] == ENA_KEY);
          RGN_ROMB: r_rbank <= data[ROM_BANK_W-1:0];
          RGN_SEL:  r_sel   <= data[3:0];
          default: ;
        endcase
      end
    end
  end

  assign w_ram_win    = ics_ram && (iadr[14:13] == RGN_RAMWIN);
  assign w_sel_is_ram = ({28'd0, r_sel} < (32'd1 << RAM_BANK_W));
  assign w_sel_is_rtc = (r_sel >= RTC_SEC) && (r_sel <= RTC_DH);
  assign w_latch_we   = w_commit && ics_rom && (iadr[14:13] == RGN_LATCH);
  assign w_reg_we     = w_commit && w_ram_win && w_sel_is_rtc && r_ena;

  // Upper ROM window never maps bank 0; every other value maps straight through.
  assign w_bank     = iadr[14] ? ((r_rbank == '0) ? ROM_BANK_W'(1) : r_rbank) : '0;
  assign w_rom_mask = AW'((32'h8000 << rom_size) - 32'd1);
  assign w_rom_adr  = {w_bank, iadr[13:0]} & w_rom_mask;

  always_comb begin
    w_ram_mask = '0;
    case (ram_size)
      2'd0:    w_ram_mask = '0;
      2'd1:    w_ram_mask = RW'(32'h07FF);
      2'd2:    w_ram_mask = RW'(32'h1FFF);
      default: w_ram_mask = RW'(32'h7FFF);
    endcase
  end

  assign w_ram_adr = {r_sel[RAM_BANK_W-1:0], iadr[12:0]} & w_ram_mask;

  assign oadr     = ics_rom ? w_rom_adr : AW'(w_ram_adr);
  assign sel_rom  = ics_rom & ~reset;
  assign sel_ram  = w_ram_win & w_sel_is_ram & r_ena & (|ram_size) & ~reset;
  assign sel_rtc  = w_ram_win & w_sel_is_rtc & r_ena & ~reset;
  assign rtc_dout = reset ? 8'h00 : w_rtc_rd;

  mbc_rtc #(
    .CLK_HZ(CLK_HZ)
  ) u_rtc (
    .clk       (clk),
    .rst       (reset),
    .i_latch_we(w_latch_we),
    .i_reg_we  (w_reg_we),
    .i_sel     (r_sel),
    .i_wdata   (data),
    .o_rdata   (w_rtc_rd)
  );

endmodule

// File: tb/tb_mbc3_rtc_chip.sv
// Directed bench for mbc3_rtc_chip with a 4-cycle RTC second.
module tb_mbc3_rtc_chip;

  logic        clk = 1'b0;
  logic        reset;
  logic        ics_rom, ics_ram, write;
  logic [14:0] iadr;
  logic [7:0]  data;
  logic [3:0]  rom_size;
  logic [1:0]  ram_size;
  logic [20:0] oadr;
  logic        sel_rom, sel_ram, sel_rtc;
  logic [7:0]  rtc_dout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mbc3_rtc_chip #(
    .ROM_BANK_W(7),
    .RAM_BANK_W(2),
    .CLK_HZ    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ics_rom (ics_rom),
    .ics_ram (ics_ram),
    .iadr    (iadr),
    .data    (data),
    .write   (write),
    .rom_size(rom_size),
    .ram_size(ram_size),
    .oadr    (oadr),
    .sel_rom (sel_rom),
    .sel_ram (sel_ram),
    .sel_rtc (sel_rtc),
    .rtc_dout(rtc_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus write: strobe high for one cycle; commit lands on the posedge after it drops.
  task automatic wr(input logic rom, input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    ics_rom = rom;
    ics_ram = ~rom;
    iadr    = a;
    data    = d;
    write   = 1'b1;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    ics_rom = 1'b0;
    ics_ram = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rtc_wr(input logic [3:0] r, input logic [7:0] d);
    wr(1'b1, 15'h4000, {4'h0, r});
    wr(1'b0, 15'h2000, d);
  endtask

  task automatic do_latch();
    wr(1'b1, 15'h6000, 8'h00);
    wr(1'b1, 15'h6000, 8'h01);
  endtask

  task automatic rd_now(input string tag, input logic [7:0] exp);
    @(negedge clk);
    ics_ram = 1'b1;
    iadr    = 15'h2000;
    #1 check(tag, {23'd0, sel_rtc, rtc_dout}, {23'd0, 1'b1, exp});
    ics_ram = 1'b0;
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] r, input logic [7:0] exp);
    wr(1'b1, 15'h4000, {4'h0, r});
    rd_now(tag, exp);
  endtask

  task automatic rom_chk(input string tag, input logic [14:0] a, input logic [20:0] exp);
    @(negedge clk);
    ics_rom = 1'b1;
    iadr    = a;
    #1 check(tag, {10'd0, sel_rom, oadr}, {10'd0, 1'b1, exp});
    ics_rom = 1'b0;
  endtask

  task automatic ram_chk(input string tag, input logic exp_sel, input logic [20:0] exp);
    @(negedge clk);
    ics_ram = 1'b1;
    iadr    = 15'h2123;
    #1 check(tag, {9'd0, sel_ram, sel_rtc, oadr}, {9'd0, exp_sel, 1'b0, exp});
    ics_ram = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ics_rom = 1'b0; ics_ram = 1'b0; write = 1'b0;
    iadr = '0; data = '0; rom_size = 4'd6; ram_size = 2'd3;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and ROM mapping
    rom_chk("rst_bank1", 15'h4000, 21'h04000);
    rom_chk("bank0", 15'h1234, 21'h01234);
    ram_chk("rst_ram_off", 1'b0, 21'h00123);
    wr(1'b1, 15'h2000, 8'h00);
    rom_chk("rbank0_to_1", 15'h4000, 21'h04000);
    wr(1'b1, 15'h2000, 8'h20);
    rom_chk("rbank20", 15'h4000, 21'h80000);
    wr(1'b1, 15'h2000, 8'hFF);
    rom_chk("rbank7f", 15'h7FFF, 21'h1FFFFF);
    rom_chk("bank0_fixed", 15'h3FFF, 21'h03FFF);
    rom_size = 4'd2;
    rom_chk("rom_mask_128k", 15'h7FFF, 21'h1FFFF);
    rom_size = 4'd6;

    // RAM enable, bank and size masks
    wr(1'b1, 15'h0000, 8'h0A);
    wr(1'b1, 15'h4000, 8'h03);
    ram_chk("ram_b3", 1'b1, 21'h06123);
    ram_size = 2'd2;
    ram_chk("ram_8k", 1'b1, 21'h00123);
    ram_size = 2'd0;
    ram_chk("ram_none", 1'b0, 21'h00000);
    ram_size = 2'd3;
    wr(1'b1, 15'h4000, 8'h05);
    ram_chk("sel_gap", 1'b0, 21'h02123);
    wr(1'b1, 15'h4000, 8'h03);
    wr(1'b1, 15'h0000, 8'h00);
    ram_chk("ram_dis", 1'b0, 21'h06123);
    wr(1'b1, 15'h0000, 8'h1A);
    ram_chk("ena_low_nibble", 1'b1, 21'h06123);

    // Full rollover: seconds written last so the next tick lands 4 edges later
    rtc_wr(4'h8, 8'd0);
    rtc_wr(4'hB, 8'hFF);
    rtc_wr(4'hC, 8'h01);
    rtc_wr(4'hA, 8'd23);
    rtc_wr(4'h9, 8'd59);
    rtc_wr(4'h8, 8'd59);
    do_latch();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    for (int r = 8; r <= 12; r++) rd_reg($sformatf("roll_%0h", r), 4'(r), exp_q.pop_front());

    // Carry is sticky unless written 0; halt bit is absent in the default build
    rtc_wr(4'hC, 8'hC0);
    do_latch();
    rd_reg("dh_sticky", 4'hC, 8'h80);
    rtc_wr(4'hC, 8'h00);
    do_latch();
    rd_reg("dh_clear", 4'hC, 8'h00);

    // Out-of-range seconds wrap without carrying into minutes
    rtc_wr(4'h8, 8'd0);
    rtc_wr(4'h9, 8'd5);
    rtc_wr(4'h8, 8'd63);
    do_latch();
    rd_reg("sec63_wrap", 4'h8, 8'd0);
    rd_reg("sec63_min", 4'h9, 8'd5);

    // Latch on the tick edge: sec=10 written at E, latch 01 commits at E+4
    rtc_wr(4'h8, 8'd0);
    wr(1'b1, 15'h6000, 8'h00);
    wr(1'b0, 15'h2000, 8'd10);
    idle(1);
    wr(1'b1, 15'h6000, 8'h01);
    rd_now("co_latch_pre", 8'd10);
    // Next latch commits at E+11, after ticks at E+4 and E+8
    do_latch();
    rd_now("co_live_ticked", 8'd12);
    wr(1'b1, 15'h6000, 8'h00);
    wr(1'b1, 15'h6000, 8'h02);
    wr(1'b1, 15'h6000, 8'h01);
    rd_now("latch_disarm", 8'd12);

    // Seconds write with the prescaler at CLK_HZ-2; next tick exactly 4 edges on
    wr(1'b0, 15'h2000, 8'd0);
    wr(1'b1, 15'h6000, 8'h00);
    idle(1);
    wr(1'b0, 15'h2000, 8'd5);
    idle(1);
    wr(1'b1, 15'h6000, 8'h01);
    rd_now("mid_count_e4", 8'd5);
    wr(1'b0, 15'h2000, 8'd0);
    wr(1'b1, 15'h6000, 8'h00);
    idle(1);
    wr(1'b0, 15'h2000, 8'd5);
    idle(2);
    wr(1'b1, 15'h6000, 8'h01);
    rd_now("mid_count_e5", 8'd6);

    // Async reset between clock edges, with the latch armed
    wr(1'b1, 15'h6000, 8'h00);
    @(negedge clk);
    ics_rom = 1'b1;
    ics_ram = 1'b1;
    iadr    = 15'h2000;
    #1 check("pre_reset", {22'd0, sel_rom, sel_rtc, rtc_dout}, {22'd0, 1'b1, 1'b1, 8'd6});
    #2 reset = 1'b1;
    #1 check("async_reset", {21'd0, sel_rom, sel_ram, sel_rtc, rtc_dout}, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    ics_rom = 1'b0;
    ics_ram = 1'b0;
    rom_chk("rst_rbank", 15'h4000, 21'h04000);
    wr(1'b1, 15'h0000, 8'h0A);
    wr(1'b1, 15'h4000, 8'h08);
    wr(1'b1, 15'h6000, 8'h01);
    rd_now("rst_arm_lost", 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
